// File: rtl/vlsu_vrf_rd_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vlsu_vrf_rd_gen                                                 |
// | Purpose  : Turns a register-level read request into a stream of VRF bank  |
// |            reads while bounding how many are in flight.                    |
// | Option   : VLSU_RDGEN_BOUNDS_CHECK_EN rejects requests that run past the  |
// |            last VRF set.                                                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vlsu_vrf_rd_gen #(
  parameter  int NrVregs    = 16,
  parameter  int NrAregs    = 16,
  parameter  int NrBanks    = 4,
  parameter  int SetPerVreg = 2,
  parameter  int SetPerAreg = 4,
  parameter  int MaxOutst   = 4,
  localparam int NrSets     = NrVregs*SetPerVreg + NrAregs*SetPerAreg,
  localparam int AregBase   = NrVregs*SetPerVreg,
  localparam int SetBits    = $clog2(NrSets),
  localparam int OffBits    = $clog2(NrBanks),
  localparam int AddrBits   = SetBits + OffBits
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_is_areg_i,
  input  logic [$clog2(NrVregs)-1:0] req_reg_i,
  input  logic [AddrBits-1:0]        req_nr_beats_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [AddrBits-1:0]        rd_addr_o,
  output logic                       rd_last_o,
  input  logic                       rsp_valid_i,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int OutBits = $clog2(MaxOutst + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rdy_en;
  logic                 r_done;
  logic                 r_err;
  logic [SetBits-1:0]   r_base;
  logic [AddrBits-1:0]  r_nr_beats;
  logic [AddrBits-1:0]  r_beat;
  logic [OutBits-1:0]   r_outst;

  logic                 w_accept;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_empty_req;
  logic                 w_bad_req;
  logic                 w_spurious;
  logic                 w_drained;
  logic [SetBits-1:0]   w_base;
  logic [SetBits-1:0]   w_set;
  logic [OffBits-1:0]   w_off;

  // Ready is held off for the cycle done_o pulses so a new request never overlaps it.
  assign req_ready_o = r_rdy_en && (r_state == IDLE) && !r_done;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_empty_req = (req_nr_beats_i == '0);

  assign rd_valid_o  = (r_state == ISSUE) && (r_outst < OutBits'(MaxOutst));
  assign w_hs        = rd_valid_o && rd_ready_i;
  assign w_last      = (r_beat == r_nr_beats - AddrBits'(1));
  assign rd_last_o   = (r_state == ISSUE) && w_last;

  assign w_set       = r_base + SetBits'(r_beat / AddrBits'(NrBanks));
  assign w_off       = OffBits'(r_beat % AddrBits'(NrBanks));
  assign rd_addr_o   = {w_set, w_off};

  assign w_spurious  = rsp_valid_i && !w_hs && (r_outst == '0);
  assign w_drained   = (r_state == DRAIN) && (r_outst == '0);
  assign done_o      = r_done;
  assign err_o       = r_err;

  always_comb begin
    w_base = SetBits'(int'(req_reg_i) * SetPerVreg);
    if (req_is_areg_i) begin
      w_base = SetBits'(AregBase + int'(req_reg_i) * SetPerAreg);
    end
  end

`ifdef VLSU_RDGEN_BOUNDS_CHECK_EN
  logic [31:0] w_final_set;

  // Full-width final set so an overrun is not hidden by set truncation.
  always_comb begin
    w_final_set = int'(req_reg_i) * SetPerVreg;
    if (req_is_areg_i) begin
      w_final_set = AregBase + int'(req_reg_i) * SetPerAreg;
    end
    w_final_set = w_final_set + (int'(req_nr_beats_i) + NrBanks - 1) / NrBanks - 1;
  end

  assign w_bad_req = !w_empty_req && (w_final_set >= 32'(NrSets));
`else
  assign w_bad_req = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && !w_empty_req && !w_bad_req) w_state_nxt = ISSUE;
      ISSUE:   if (w_hs && w_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_outst == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdy_en   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_base     <= '0;
      r_nr_beats <= '0;
      r_beat     <= '0;
      r_outst    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_done   <= (w_accept && w_empty_req) || w_drained;
      r_err    <= w_spurious || (w_accept && w_bad_req);

      if (w_accept) begin
        r_base     <= w_base;
        r_nr_beats <= req_nr_beats_i;
        r_beat     <= '0;
      end else if (w_hs) begin
        r_beat <= r_beat + AddrBits'(1);
      end

      // A response with nothing outstanding is reported, never counted.
      unique case ({w_hs, rsp_valid_i})
        2'b10:   r_outst <= r_outst + OutBits'(1);
        2'b01:   if (r_outst != '0) r_outst <= r_outst - OutBits'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vlsu_vrf_rd_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vlsu_vrf_rd_gen                                              |
// | Purpose  : Bench for vlsu_vrf_rd_gen against a transaction-level model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vlsu_vrf_rd_gen;

  logic       clk_i;
  logic       rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_is_areg_i;
  logic [3:0] req_reg_i;
  logic [8:0] req_nr_beats_i;
  logic       rd_valid_o;
  logic       rd_ready_i;
  logic [8:0] rd_addr_o;
  logic       rd_last_o;
  logic       rsp_valid_i;
  logic       done_o;
  logic       err_o;

  vlsu_vrf_rd_gen dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_is_areg_i  (req_is_areg_i),
    .req_reg_i      (req_reg_i),
    .req_nr_beats_i (req_nr_beats_i),
    .rd_valid_o     (rd_valid_o),
    .rd_ready_i     (rd_ready_i),
    .rd_addr_o      (rd_addr_o),
    .rd_last_o      (rd_last_o),
    .rsp_valid_i    (rsp_valid_i),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: list of addresses still to be read plus in-flight count.
  int  m_q[$];
  int  m_outst   = 0;
  bit  m_issuing = 0;
  bit  m_draining = 0;
  bit  m_ready   = 0;
  bit  m_rdy_en  = 0;
  bit  m_done    = 0;
  bit  m_err     = 0;
  bit  m_prev_hs = 0;
  bit  m_acc     = 0;

  int  n_reads, n_dones, n_errs, first_addr, last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_scn();
    n_reads = 0; n_dones = 0; n_errs = 0; first_addr = -1; last_addr = -1;
  endtask

  // One clock cycle: inputs are already driven, check outputs, advance model.
  task automatic tick();
    bit exp_valid, hs, acc, nxt_done, nxt_err, bad;
    int base, n;
    #1;
    exp_valid = m_issuing && (m_outst < 4);
    chk("req_ready", req_ready_o, m_ready);
    chk("rd_valid", rd_valid_o, exp_valid);
    if (exp_valid) begin
      chk("rd_addr", rd_addr_o, m_q[0]);
      chk("rd_last", rd_last_o, (m_q.size() == 1));
    end
    chk("done", done_o, m_done);
    chk("err", err_o, m_err);

    if (rd_valid_o && rd_ready_i) begin
      if (n_reads == 0) first_addr = rd_addr_o;
      last_addr = rd_addr_o;
      n_reads++;
    end
    if (done_o) n_dones++;
    if (err_o) n_errs++;

    hs = exp_valid && rd_ready_i;
    acc = req_valid_i && m_ready;
    nxt_done = 0;
    nxt_err = 0;
    if (m_draining && m_outst == 0) begin
      m_draining = 0;
      nxt_done = 1;
    end
    if (hs) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_issuing = 0;
        m_draining = 1;
      end
    end
    if (rsp_valid_i && !hs) begin
      if (m_outst == 0) nxt_err = 1;
      else m_outst--;
    end else if (hs && !rsp_valid_i) begin
      m_outst++;
    end
    m_acc = acc;
    if (acc) begin
      base = req_is_areg_i ? 32 + int'(req_reg_i) * 4 : int'(req_reg_i) * 2;
      n = int'(req_nr_beats_i);
      bad = 0;
`ifdef VLSU_RDGEN_BOUNDS_CHECK_EN
      if (n != 0 && base + (n + 3) / 4 - 1 >= 96) bad = 1;
`endif
      if (n == 0) nxt_done = 1;
      else if (bad) nxt_err = 1;
      else begin
        for (int b = 0; b < n; b++) m_q.push_back((((base + b / 4) % 128) * 4) + b % 4);
        m_issuing = 1;
      end
    end
    m_prev_hs = hs;
    m_done = nxt_done;
    m_err = nxt_err;
    m_ready = m_rdy_en && !m_issuing && !m_draining && !nxt_done;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_last", rd_last_o, 0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    m_q.delete();
    m_outst = 0; m_issuing = 0; m_draining = 0; m_ready = 0; m_rdy_en = 0;
    m_done = 0; m_err = 0; m_prev_hs = 0;
    req_valid_i = 1'b0;
    rsp_valid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_hold_ready", req_ready_o, 0);
    rst_i = 1'b0;
    m_rdy_en = 1;
  endtask

  task automatic send(input bit a, input int r, input int n);
    int k = 0;
    req_is_areg_i = a;
    req_reg_i = 4'(r);
    req_nr_beats_i = 9'(n);
    req_valid_i = 1'b1;
    m_acc = 0;
    while (!m_acc && k < 40) begin
      tick();
      k++;
    end
    req_valid_i = 1'b0;
    chk("req_accepted", m_acc, 1);
  endtask

  // mode 1: ready always, response one cycle after each read; mode 2: random.
  task automatic run_idle(input int mode, input int budget);
    int k = 0;
    bit idle;
    idle = m_ready && !m_issuing && !m_draining;
    while (!idle && k < budget) begin
      if (mode == 1) begin
        rd_ready_i = 1'b1;
        rsp_valid_i = m_prev_hs;
      end else begin
        rd_ready_i = 1'($urandom % 2);
        rsp_valid_i = (m_outst > 0) && ($urandom % 3 != 0);
      end
      tick();
      k++;
      idle = m_ready && !m_issuing && !m_draining;
    end
    rsp_valid_i = 1'b0;
    chk("idle_reached", idle, 1);
  endtask

  initial begin
    rst_i = 1'b0; req_valid_i = 1'b0; req_is_areg_i = 1'b0; req_reg_i = '0;
    req_nr_beats_i = '0; rd_ready_i = 1'b0; rsp_valid_i = 1'b0;
    #3;
    apply_reset();
    tick();

    // vreg 3, six beats, responses trailing each read by one cycle
    start_scn();
    rd_ready_i = 1'b1;
    send(0, 3, 6);
    run_idle(1, 100);
    chk("vreg_reads", n_reads, 6);
    chk("vreg_first", first_addr, 24);
    chk("vreg_last", last_addr, 29);
    chk("vreg_done", n_dones, 1);

    // areg 1, two beats
    start_scn();
    send(1, 1, 2);
    run_idle(1, 100);
    chk("areg_first", first_addr, 144);
    chk("areg_last", last_addr, 145);
    chk("areg_done", n_dones, 1);

    // outstanding limit
    start_scn();
    rd_ready_i = 1'b1;
    rsp_valid_i = 1'b0;
    send(0, 0, 8);
    repeat (10) tick();
    chk("outst_reads", n_reads, 4);
    chk("outst_stall", rd_valid_o, 0);
    rsp_valid_i = 1'b1;
    tick();
    rsp_valid_i = 1'b0;
    repeat (5) tick();
    chk("outst_one_more", n_reads, 5);
    chk("outst_addr", last_addr, 4);
    run_idle(2, 300);

    // request running past the last set
    start_scn();
    rd_ready_i = 1'b1;
    send(1, 15, 20);
    run_idle(1, 200);
`ifdef VLSU_RDGEN_BOUNDS_CHECK_EN
    chk("bounds_reads", n_reads, 0);
    chk("bounds_err", n_errs, 1);
`else
    chk("bounds_reads", n_reads, 20);
    chk("bounds_first", first_addr, 368);
`endif

    // zero-beat request
    start_scn();
    send(0, 5, 0);
    run_idle(1, 20);
    tick();
    chk("zero_reads", n_reads, 0);
    chk("zero_done", n_dones, 1);

    // stray response while idle
    start_scn();
    rsp_valid_i = 1'b1;
    tick();
    rsp_valid_i = 1'b0;
    tick();
    chk("spurious_err", n_errs, 1);

    // reset after two of six beats
    start_scn();
    rd_ready_i = 1'b1;
    send(0, 2, 6);
    for (int k = 0; k < 10 && n_reads < 2; k++) tick();
    chk("pre_rst_reads", n_reads, 2);
    apply_reset();
    tick();
    tick();
    start_scn();
    send(0, 1, 3);
    run_idle(1, 100);
    chk("post_rst_first", first_addr, 8);
    chk("post_rst_reads", n_reads, 3);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      int n;
      n = ($urandom % 8 == 0) ? int'($urandom_range(14, 40)) : int'($urandom % 14);
      rd_ready_i = 1'($urandom % 2);
      send(1'($urandom % 2), int'($urandom % 16), n);
      run_idle(2, 600);
      if ($urandom % 5 == 0) begin
        rsp_valid_i = 1'b1;
        tick();
        rsp_valid_i = 1'b0;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
